seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl_pkg.sv | 24 ++
 rtl/seven_seg.sv | 30 +++
 rtl/seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment bit
// positions, the all-dark segment word and the default slot length.
package seg_scan_ctrl_pkg;

   localparam int DEFAULT_SLOT_CYCLES = 20000;

   // Bit positions inside the active-low segment word
   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Every segment and the decimal point dark
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Assemble a full active-low segment word from a dp flag and decoded g..a
   function automatic logic [7:0] seg_word(input logic dp_on, input logic [6:0] gfa_n);
      logic [7:0] w;
      w              = SEG_OFF;
      w[SEG_DP]      = ~dp_on;
      w[SEG_G:SEG_A] = gfa_n;
      return w;
   endfunction

endpackage

// File: rtl/seven_seg.sv
// Hex nibble to active-low seven-segment decoder (bits [6:0] = g..a).
module seven_seg (
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   // Standard 0-F glyph table, active-low
   always_comb begin
      case (hex)
         4'h0:    seg_n = 7'b100_0000;
         4'h1:    seg_n = 7'b111_1001;
         4'h2:    seg_n = 7'b010_0100;
         4'h3:    seg_n = 7'b011_0000;
         4'h4:    seg_n = 7'b001_1001;
         4'h5:    seg_n = 7'b001_0010;
         4'h6:    seg_n = 7'b000_0010;
         4'h7:    seg_n = 7'b111_1000;
         4'h8:    seg_n = 7'b000_0000;
         4'h9:    seg_n = 7'b001_0000;
         4'hA:    seg_n = 7'b000_1000;
         4'hB:    seg_n = 7'b000_0011;
         4'hC:    seg_n = 7'b100_0110;
         4'hD:    seg_n = 7'b010_0001;
         4'hE:    seg_n = 7'b000_0110;
         4'hF:    seg_n = 7'b000_1110;
         default: seg_n = 7'b111_1111;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with per-digit dp/blank,
// leading-zero suppression, PWM brightness and double-buffered loading.
// The scan reads only the active buffer, which is replaced from the pending
// buffer exactly at the frame boundary, so a frame never mixes old and new data.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
   parameter int BRIGHT_W    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*N_DIGITS-1:0]   digits,
   input  logic [N_DIGITS-1:0]     dp,
   input  logic [N_DIGITS-1:0]     blank,
   input  logic                    lzs_en,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    load,
   output logic [7:0]              segments_n,
   output logic [N_DIGITS-1:0]     anodes_n,
   output logic                    frame_tick
);

   localparam int CW = $clog2(SLOT_CYCLES);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   // Wide enough for (2**BRIGHT_W) * SLOT_CYCLES without overflow
   localparam int OW = BRIGHT_W + CW + 1;

   localparam logic [CW-1:0] SLOT_LAST     = CW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST      = IW'(N_DIGITS - 1);
   localparam logic [OW-1:0] SLOT_CYCLES_W = OW'(SLOT_CYCLES);

   // Scan position
   logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
   logic [IW-1:0]           idx_q, idx_d;

   // Pending (written by load) and active (read by scan) buffers
   logic [4*N_DIGITS-1:0]   pend_digits_q, pend_digits_d;
   logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic [N_DIGITS-1:0]     pend_blank_q, pend_blank_d;
   logic                    pend_lzs_q, pend_lzs_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [4*N_DIGITS-1:0]   act_digits_q, act_digits_d;
   logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
   logic [N_DIGITS-1:0]     act_blank_q, act_blank_d;
   logic                    act_lzs_q, act_lzs_d;

   // Registered pin drivers
   logic [7:0]              segments_n_q, segments_n_d;
   logic [N_DIGITS-1:0]     anodes_n_q, anodes_n_d;
   logic                    frame_tick_q, frame_tick_d;

   // Combinational helpers
   logic                    slot_wrap_s;
   logic                    frame_wrap_s;
   logic [BRIGHT_W:0]       bright_p1_s;
   logic [OW-1:0]           on_cycles_s;
   logic [N_DIGITS-1:0]     supp_s;
   logic                    zero_run_s;
   logic [3:0]              nibble_s;
   logic                    dp_sel_s;
   logic                    blank_sel_s;
   logic                    supp_sel_s;
   logic                    lit_s;
   logic [6:0]              dec_seg_n_s;

   seven_seg u_seven_seg (
      .hex   (nibble_s),
      .seg_n (dec_seg_n_s)
   );

   // PWM on-time for the current brightness setting
   always_comb begin
      bright_p1_s = {1'b0, brightness} + {{BRIGHT_W{1'b0}}, 1'b1};
      on_cycles_s = (OW'(bright_p1_s) * SLOT_CYCLES_W) >> BRIGHT_W;
   end

   // Leading-zero suppression: walk from the top digit down while nibbles are zero
   always_comb begin
      zero_run_s = 1'b1;
      supp_s     = {N_DIGITS{1'b0}};
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run_s = zero_run_s & (act_digits_q[4*i +: 4] == 4'h0);
         supp_s[i]  = act_lzs_q & zero_run_s & (i != 0);
      end
   end

   // Select the active-buffer data for the digit currently being scanned
   always_comb begin
      nibble_s    = act_digits_q[{idx_q, 2'b00} +: 4];
      dp_sel_s    = act_dp_q[idx_q];
      blank_sel_s = act_blank_q[idx_q];
      supp_sel_s  = supp_s[idx_q];
      lit_s       = (OW'(slot_cnt_q) < on_cycles_s) & ~blank_sel_s & ~supp_sel_s;
   end

   // Next-state for scan counters, buffers and pin drivers
   always_comb begin
      slot_wrap_s  = (slot_cnt_q == SLOT_LAST);
      frame_wrap_s = slot_wrap_s & (idx_q == IDX_LAST);

      if (slot_wrap_s) begin
         slot_cnt_d = {CW{1'b0}};
      end else begin
         slot_cnt_d = slot_cnt_q + CW'(1'b1);
      end

      if (frame_wrap_s) begin
         idx_d = {IW{1'b0}};
      end else if (slot_wrap_s) begin
         idx_d = idx_q + IW'(1'b1);
      end else begin
         idx_d = idx_q;
      end

      // Old pending data commits at the boundary even if a new load arrives now
      if (frame_wrap_s && pend_valid_q) begin
         act_digits_d = pend_digits_q;
         act_dp_d     = pend_dp_q;
         act_blank_d  = pend_blank_q;
         act_lzs_d    = pend_lzs_q;
      end else begin
         act_digits_d = act_digits_q;
         act_dp_d     = act_dp_q;
         act_blank_d  = act_blank_q;
         act_lzs_d    = act_lzs_q;
      end

      if (load) begin
         pend_digits_d = digits;
         pend_dp_d     = dp;
         pend_blank_d  = blank;
         pend_lzs_d    = lzs_en;
         pend_valid_d  = 1'b1;
      end else if (frame_wrap_s) begin
         pend_digits_d = pend_digits_q;
         pend_dp_d     = pend_dp_q;
         pend_blank_d  = pend_blank_q;
         pend_lzs_d    = pend_lzs_q;
         pend_valid_d  = 1'b0;
      end else begin
         pend_digits_d = pend_digits_q;
         pend_dp_d     = pend_dp_q;
         pend_blank_d  = pend_blank_q;
         pend_lzs_d    = pend_lzs_q;
         pend_valid_d  = pend_valid_q;
      end

      if (lit_s) begin
         segments_n_d = seg_word(dp_sel_s, dec_seg_n_s);
         for (int i = 0; i < N_DIGITS; i++) begin
            anodes_n_d[i] = ~(idx_q == IW'(i));
         end
      end else begin
         segments_n_d = SEG_OFF;
         anodes_n_d   = {N_DIGITS{1'b1}};
      end

      frame_tick_d = frame_wrap_s;
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_cnt_q    <= {CW{1'b0}};
         idx_q         <= {IW{1'b0}};
         pend_digits_q <= {(4*N_DIGITS){1'b0}};
         pend_dp_q     <= {N_DIGITS{1'b0}};
         pend_blank_q  <= {N_DIGITS{1'b0}};
         pend_lzs_q    <= 1'b0;
         pend_valid_q  <= 1'b0;
         act_digits_q  <= {(4*N_DIGITS){1'b0}};
         act_dp_q      <= {N_DIGITS{1'b0}};
         act_blank_q   <= {N_DIGITS{1'b0}};
         act_lzs_q     <= 1'b0;
         segments_n_q  <= SEG_OFF;
         anodes_n_q    <= {N_DIGITS{1'b1}};
         frame_tick_q  <= 1'b0;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         idx_q         <= idx_d;
         pend_digits_q <= pend_digits_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         pend_lzs_q    <= pend_lzs_d;
         pend_valid_q  <= pend_valid_d;
         act_digits_q  <= act_digits_d;
         act_dp_q      <= act_dp_d;
         act_blank_q   <= act_blank_d;
         act_lzs_q     <= act_lzs_d;
         segments_n_q  <= segments_n_d;
         anodes_n_q    <= anodes_n_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign segments_n = segments_n_q;
   assign anodes_n   = anodes_n_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (N_DIGITS=4, SLOT_CYCLES=8, BRIGHT_W=3).
// A cycle model pushes the expected pin values into a scoreboard before each
// edge; they are popped and compared one edge later when the DUT shows them.
// Directed frame checks use hand-written segment/anode constants.
module tb_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int S  = 8;
   localparam int BW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   digits;
   logic [3:0]    dp;
   logic [3:0]    blank;
   logic          lzs_en;
   logic [2:0]    brightness;
   logic          load;
   logic [7:0]    segments_n;
   logic [3:0]    anodes_n;
   logic          frame_tick;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .N_DIGITS    (N),
      .SLOT_CYCLES (S),
      .BRIGHT_W    (BW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits     (digits),
      .dp         (dp),
      .blank      (blank),
      .lzs_en     (lzs_en),
      .brightness (brightness),
      .load       (load),
      .segments_n (segments_n),
      .anodes_n   (anodes_n),
      .frame_tick (frame_tick)
   );

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] an;
      logic       ft;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Active-high gfedcba glyphs for 0-F
   logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model state
   int          m_slot = 0;
   int          m_idx  = 0;
   logic [15:0] m_pend_dig = 16'h0, m_act_dig = 16'h0;
   logic [3:0]  m_pend_dp = 4'h0, m_act_dp = 4'h0;
   logic [3:0]  m_pend_blank = 4'h0, m_act_blank = 4'h0;
   logic        m_pend_lzs = 1'b0, m_act_lzs = 1'b0, m_pend_valid = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      int   on;
      logic [3:0] nib;
      logic supp, lit;
      if (!rst_n) begin
         e.seg = 8'hFF; e.an = 4'hF; e.ft = 1'b0;
      end else begin
         on   = ((int'(brightness) + 1) * S) >> BW;
         nib  = m_act_dig[4*m_idx +: 4];
         supp = m_act_lzs && (m_idx != 0) && ((m_act_dig >> (4*m_idx)) == 16'h0);
         lit  = (m_slot < on) && !m_act_blank[m_idx] && !supp;
         e.seg = lit ? {~m_act_dp[m_idx], ~seg_hi[nib]} : 8'hFF;
         e.an  = lit ? ~(4'b0001 << m_idx) : 4'hF;
         e.ft  = (m_slot == S-1) && (m_idx == N-1);
      end
      return e;
   endfunction

   task automatic model_advance();
      logic boundary;
      if (!rst_n) begin
         m_slot = 0; m_idx = 0;
         m_pend_dig = 16'h0; m_pend_dp = 4'h0; m_pend_blank = 4'h0; m_pend_lzs = 1'b0;
         m_pend_valid = 1'b0;
         m_act_dig = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'h0; m_act_lzs = 1'b0;
      end else begin
         boundary = (m_slot == S-1) && (m_idx == N-1);
         if (boundary && m_pend_valid) begin
            m_act_dig = m_pend_dig; m_act_dp = m_pend_dp;
            m_act_blank = m_pend_blank; m_act_lzs = m_pend_lzs;
         end
         if (load) begin
            m_pend_dig = digits; m_pend_dp = dp; m_pend_blank = blank; m_pend_lzs = lzs_en;
            m_pend_valid = 1'b1;
         end else if (boundary) begin
            m_pend_valid = 1'b0;
         end
         if (m_slot == S-1) begin
            m_slot = 0;
            m_idx  = (m_idx + 1) % N;
         end else begin
            m_slot = m_slot + 1;
         end
      end
   endtask

   // One clock: push expectation, clock, pop and compare #1 after the edge
   task automatic step();
      exp_t e;
      sb_q.push_back(model_out());
      @(posedge clk);
      model_advance();
      #1;
      e = sb_q.pop_front();
      check_val("sb_seg", {24'h0, segments_n}, {24'h0, e.seg});
      check_val("sb_an", {28'h0, anodes_n}, {28'h0, e.an});
      check_val("sb_ft", {31'h0, frame_tick}, {31'h0, e.ft});
   endtask

   // Clock until the DUT pulses frame_tick; n returns the cycles taken
   task automatic run_until_tick(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         n++;
         if (frame_tick === 1'b1) return;
      end
      check_val("tick_timeout", 32'd0, 32'd1);
   endtask

   // Check one whole frame against hand constants; starts right after a tick
   task automatic frame_expect(input string tag, input logic [31:0] segs,
                               input logic [15:0] ans, input int on);
      for (int k = 0; k < 32; k++) begin
         int d;
         int s;
         d = k / 8;
         s = k % 8;
         step();
         if (s < on) begin
            check_val({tag, "_an"}, {28'h0, anodes_n}, {28'h0, ans[4*d +: 4]});
            check_val({tag, "_seg"}, {24'h0, segments_n}, {24'h0, segs[8*d +: 8]});
         end else begin
            check_val({tag, "_an_off"}, {28'h0, anodes_n}, 32'hF);
            check_val({tag, "_seg_off"}, {24'h0, segments_n}, 32'hFF);
         end
         check_val({tag, "_ft"}, {31'h0, frame_tick}, {31'h0, (k == 31)});
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                          input logic [3:0] b, input logic z);
      digits = d; dp = p; blank = b; lzs_en = z; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; digits = 16'h0; dp = 4'h0; blank = 4'h0; lzs_en = 1'b0;
      brightness = 3'd7; load = 1'b0;

      // Reset state
      step();
      step();
      check_val("rst_an", {28'h0, anodes_n}, 32'hF);
      check_val("rst_seg", {24'h0, segments_n}, 32'hFF);
      check_val("rst_ft", {31'h0, frame_tick}, 32'h0);
      rst_n = 1'b1;

      // First edge after release: digit 0 lit showing '0' from cleared buffer
      do_load(16'h1234, 4'h0, 4'h0, 1'b0);
      check_val("first_an", {28'h0, anodes_n}, 32'hE);
      check_val("first_seg", {24'h0, segments_n}, 32'hC0);

      // Basic scan of 1234 at full brightness, tick every 32 cycles
      run_until_tick(n);
      frame_expect("f1234", 32'hF9A4B099, 16'h7BDE, 8);

      // Brightness 1: two of eight cycles lit per digit
      brightness = 3'd1;
      frame_expect("dim", 32'hF9A4B099, 16'h7BDE, 2);
      brightness = 3'd7;

      // Leading-zero suppression
      do_load(16'h0070, 4'h0, 4'h0, 1'b1);
      run_until_tick(n);
      frame_expect("lzs70", 32'hFFFFF8C0, 16'hFFDE, 8);
      do_load(16'h0000, 4'h0, 4'h0, 1'b1);
      run_until_tick(n);
      frame_expect("lzs00", 32'hFFFFFFC0, 16'hFFFE, 8);

      // Blank and decimal points
      do_load(16'h1234, 4'b0101, 4'b0100, 1'b0);
      run_until_tick(n);
      frame_expect("blkdp", 32'hF9FFB019, 16'h7FDE, 8);

      // Two loads mid-frame: current frame unchanged, next shows the latest
      for (int i = 0; i < 10; i++) step();
      do_load(16'h1111, 4'h0, 4'h0, 1'b0);
      step();
      do_load(16'h2222, 4'h0, 4'h0, 1'b0);
      run_until_tick(n);
      frame_expect("f2222", 32'hA4A4A4A4, 16'h7BDE, 8);

      // Load on the boundary cycle while an older load is still pending
      for (int i = 0; i < 5; i++) step();
      do_load(16'h9999, 4'h0, 4'h0, 1'b0);
      for (int i = 0; i < 64 && !((m_slot == S-1) && (m_idx == N-1)); i++) step();
      check_val("at_boundary", {31'h0, ((m_slot == S-1) && (m_idx == N-1))}, 32'h1);
      do_load(16'h5678, 4'h0, 4'h0, 1'b0);
      check_val("bnd_ft", {31'h0, frame_tick}, 32'h1);
      frame_expect("f9999", 32'h90909090, 16'h7BDE, 8);
      frame_expect("f5678", 32'h9282F880, 16'h7BDE, 8);

      // One-cycle reset mid-slot
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b0;
      step();
      check_val("mid_rst_an", {28'h0, anodes_n}, 32'hF);
      check_val("mid_rst_seg", {24'h0, segments_n}, 32'hFF);
      check_val("mid_rst_ft", {31'h0, frame_tick}, 32'h0);
      rst_n = 1'b1;
      step();
      check_val("restart_an", {28'h0, anodes_n}, 32'hE);
      check_val("restart_seg", {24'h0, segments_n}, 32'hC0);
      run_until_tick(n);
      check_val("restart_tick_gap", n, 32'd31);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
